// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master single-port RAM arbiter with last-granted tie break,
// bounded bursts and per-master read response routing.
module mem_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rv0_q, rv0_d, rv1_q, rv1_d;
  logic        xfer0, xfer1, burst_done;
  assign m0_gnt    = state_q == OWN0;
  assign m1_gnt    = state_q == OWN1;
  assign xfer0     = m0_gnt && m0_req;
  assign xfer1     = m1_gnt && m1_req;
  assign ram_en    = xfer0 || xfer1;
  assign ram_we    = xfer0 ? m0_we : (xfer1 && m1_we);
  assign ram_addr  = xfer1 ? m1_addr : m0_addr;
  assign ram_wdata = xfer1 ? m1_wdata : m0_wdata;
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = rv0_q ? ram_rdata : '0;
  assign m1_rdata  = rv1_q ? ram_rdata : '0;
  // The current transfer is the last allowed one of the burst once the counter reaches MAX_BURST-1.
  assign burst_done = cnt_q >= 8'(MAX_BURST - 1);
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = (m0_req && (!m1_req || last_q)) ? OWN0 : m1_req ? OWN1 : IDLE;
      OWN0: state_d = !m0_req ? (m1_req ? OWN1 : IDLE) : (m1_req && burst_done) ? OWN1 : OWN0;
      OWN1: state_d = !m1_req ? (m0_req ? OWN0 : IDLE) : (m0_req && burst_done) ? OWN0 : OWN1;
      default: state_d = IDLE;
    endcase
    cnt_d  = (state_d != state_q) ? 8'd0 : (ram_en && cnt_q < 8'(MAX_BURST)) ? cnt_q + 8'd1 : cnt_q;
    last_d = (state_d == OWN0 && state_q != OWN0) ? 1'b0 :
             (state_d == OWN1 && state_q != OWN1) ? 1'b1 : last_q;
    rv0_d  = xfer0 && !m0_we;
    rv1_d  = xfer1 && !m1_we;
  end
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end
endmodule
